// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-requester RAM arbiter: sequencer state
// encoding and requester index constants.
package ram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WR   = 2'd1,
      RD1  = 2'd2,
      RD2  = 2'd3
   } state_t;

   localparam logic REQ_IDX0 = 1'b0;
   localparam logic REQ_IDX1 = 1'b1;

endpackage

// File: rtl/ram_arbiter_if.sv
// Bundle of the two requester ports and the RAM-side port of ram_arbiter.
// slave = arbiter side, master = clients plus RAM.
interface ram_arbiter_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 10
) ();

   logic                  REQ0;
   logic                  WE0;
   logic [ADDR_WIDTH-1:0] ADDR0;
   logic [DATA_WIDTH-1:0] DIN0;
   logic                  ACK0;
   logic [DATA_WIDTH-1:0] DOUT0;

   logic                  REQ1;
   logic                  WE1;
   logic [ADDR_WIDTH-1:0] ADDR1;
   logic [DATA_WIDTH-1:0] DIN1;
   logic                  ACK1;
   logic [DATA_WIDTH-1:0] DOUT1;

   logic                  BUSY;
   logic                  RAM_EN;
   logic                  RAM_WE;
   logic [ADDR_WIDTH-1:0] RAM_ADDR;
   logic [DATA_WIDTH-1:0] RAM_DIN;
   logic [DATA_WIDTH-1:0] RAM_DOUT;

   modport slave (
      input  REQ0, WE0, ADDR0, DIN0,
      input  REQ1, WE1, ADDR1, DIN1,
      input  RAM_DOUT,
      output ACK0, DOUT0, ACK1, DOUT1,
      output BUSY, RAM_EN, RAM_WE, RAM_ADDR, RAM_DIN
   );

   modport master (
      output REQ0, WE0, ADDR0, DIN0,
      output REQ1, WE1, ADDR1, DIN1,
      output RAM_DOUT,
      input  ACK0, DOUT0, ACK1, DOUT1,
      input  BUSY, RAM_EN, RAM_WE, RAM_ADDR, RAM_DIN
   );

endinterface

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin grant; the LAST register is owned by
// the parent so this block stays stateless.
module rr_arb2
   import ram_arb_pkg::*;
(
   input  logic [1:0] eligible,
   input  logic       last,
   output logic       grant_valid,
   output logic       grant_idx
);

   always_comb begin
      grant_valid = |eligible;
      if (eligible == 2'b11)
         grant_idx = ~last;
      else if (eligible[1])
         grant_idx = REQ_IDX1;
      else
         grant_idx = REQ_IDX0;
   end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter and sequencer that serialises two requesters onto one
// single-port synchronous RAM and returns a one-cycle ACK per transaction.
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 10
) (
   input  logic          CLK,
   input  logic          RST,
   ram_arbiter_if.slave  bus
);

   state_t                state;
   logic                  last;
   logic                  cur;
   logic                  ack0, ack1, busy;
   logic                  ram_en, ram_we;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [DATA_WIDTH-1:0] ram_din;
   logic [DATA_WIDTH-1:0] dout0, dout1;

   logic [1:0]            eligible;
   logic                  grant_valid, grant_idx;
   logic                  sel_we;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_din;

   // A requester in its own ACK cycle is masked so it cannot be served twice.
   assign eligible = {bus.REQ1 & ~ack1, bus.REQ0 & ~ack0};

   rr_arb2 u_rr_arb2 (
      .eligible    (eligible),
      .last        (last),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx)
   );

   assign sel_we   = (grant_idx == REQ_IDX1) ? bus.WE1   : bus.WE0;
   assign sel_addr = (grant_idx == REQ_IDX1) ? bus.ADDR1 : bus.ADDR0;
   assign sel_din  = (grant_idx == REQ_IDX1) ? bus.DIN1  : bus.DIN0;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state    <= IDLE;
         last     <= REQ_IDX1;
         cur      <= REQ_IDX0;
         ack0     <= 1'b0;
         ack1     <= 1'b0;
         busy     <= 1'b0;
         ram_en   <= 1'b0;
         ram_we   <= 1'b0;
         ram_addr <= '0;
         ram_din  <= '0;
         dout0    <= '0;
         dout1    <= '0;
      end else begin
         ack0 <= 1'b0;
         ack1 <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_valid) begin
                  last     <= grant_idx;
                  cur      <= grant_idx;
                  ram_en   <= 1'b1;
                  ram_we   <= sel_we;
                  ram_addr <= sel_addr;
                  ram_din  <= sel_din;
                  busy     <= 1'b1;
                  state    <= sel_we ? WR : RD1;
               end
            end
            WR: begin
               ram_en <= 1'b0;
               ram_we <= 1'b0;
               busy   <= 1'b0;
               if (cur == REQ_IDX1) ack1 <= 1'b1;
               else                 ack0 <= 1'b1;
               state  <= IDLE;
            end
            // RAM registers the read data at the end of RD1; it is sampled in RD2.
            RD1: state <= RD2;
            RD2: begin
               ram_en <= 1'b0;
               busy   <= 1'b0;
               if (cur == REQ_IDX1) begin
                  dout1 <= bus.RAM_DOUT;
                  ack1  <= 1'b1;
               end else begin
                  dout0 <= bus.RAM_DOUT;
                  ack0  <= 1'b1;
               end
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.ACK0     = ack0;
   assign bus.ACK1     = ack1;
   assign bus.DOUT0    = dout0;
   assign bus.DOUT1    = dout1;
   assign bus.BUSY     = busy;
   assign bus.RAM_EN   = ram_en;
   assign bus.RAM_WE   = ram_we;
   assign bus.RAM_ADDR = ram_addr;
   assign bus.RAM_DIN  = ram_din;

endmodule
